// File: rtl/core_pkg.sv
// Shared core types: ALU command encoding and the decoder-facing instruction types
// used by instr_stencil and the nibble-serial ALU.
package core_pkg;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_SLT  = 3'd5,
    ALU_SLTU = 3'd6,
    ALU_RSVD = 3'd7
  } AluCtrl;

  typedef logic [4:0]  RegAddr;
  typedef logic [31:0] Instruction;

  typedef enum logic [6:0] {
    OPC_LOAD   = 7'b0000011,
    OPC_OP_IMM = 7'b0010011,
    OPC_AUIPC  = 7'b0010111,
    OPC_STORE  = 7'b0100011,
    OPC_OP     = 7'b0110011,
    OPC_LUI    = 7'b0110111,
    OPC_BRANCH = 7'b1100011,
    OPC_JALR   = 7'b1100111,
    OPC_JAL    = 7'b1101111,
    OPC_SYSTEM = 7'b1110011
  } OpCode;

  typedef struct packed {
    AluCtrl ctrl;
    logic   one_nibble;
    logic   use_imm;
    RegAddr rd;
    RegAddr rs1;
    RegAddr rs2;
  } DecodedAluCmd;

  localparam int unsigned NIBBLES = 8;

  // Subtract-style ops feed an inverted operand B with carry-in 1 at nibble 0.
  function automatic logic ctrl_is_sub(AluCtrl c);
    return (c == ALU_SUB) || (c == ALU_SLT) || (c == ALU_SLTU);
  endfunction

endpackage

// File: rtl/loop_over_all_nibbles_if.sv
// Caller <-> nibble-serial ALU handshake and operand/result bus.
interface loop_over_all_nibbles_if;
  import core_pkg::*;

  logic        loop_perm_to_count;
  logic        loop_over_one_nibble;
  AluCtrl      ctrl;
  logic [31:0] word1;
  logic [31:0] word2;
  logic [31:0] result;
  logic        busy;
  logic        result_carry;

  modport master (
    output loop_perm_to_count, loop_over_one_nibble, ctrl, word1, word2,
    input  result, busy, result_carry
  );

  modport slave (
    input  loop_perm_to_count, loop_over_one_nibble, ctrl, word1, word2,
    output result, busy, result_carry
  );

endinterface

// File: rtl/nibble_alu.sv
// Combinational 4-bit ALU slice; logic ops report no carry-out.
module nibble_alu
  import core_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  input  AluCtrl     ctrl,
  output logic [3:0] y,
  output logic       cout,
  output logic       sign,
  output logic       overflow
);

  logic [3:0] b_eff;
  logic [4:0] sum;

  // Adder path shared by ADD/SUB/SLT/SLTU, logic ops selected over it.
  always_comb begin
    b_eff    = ctrl_is_sub(ctrl) ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {4'd0, cin};
    sign     = sum[3];
    overflow = (a[3] == b_eff[3]) && (sum[3] != a[3]);
    case (ctrl)
      ALU_AND: begin y = a & b; cout = 1'b0; end
      ALU_OR:  begin y = a | b; cout = 1'b0; end
      ALU_XOR: begin y = a ^ b; cout = 1'b0; end
      default: begin y = sum[3:0]; cout = sum[4]; end
    endcase
  end

endmodule

// File: rtl/loop_over_all_nibbles.sv
// Nibble-serial 32-bit ALU: one 4-bit slice per clock, LSB first, carry chained
// through a register; optional one-nibble increment mode with early stop.
module loop_over_all_nibbles
  import core_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  loop_over_all_nibbles_if.slave  bus
);

  logic [2:0]  curr_nibble_idx_q, curr_nibble_idx_d;
  logic        carry_q, carry_d;
  logic [31:0] result_q, result_d;
  logic        result_carry_q, result_carry_d;

  logic        perm_to_count;
  logic        one_nib;
  AluCtrl      op;
  logic        last_nib;
  logic [3:0]  a_nib, b_nib, y_nib;
  logic        cin, cout, sign, ovf;
  logic        early_done, busy, lt;

  nibble_alu u_nibble_alu (
    .a        (a_nib),
    .b        (b_nib),
    .cin      (cin),
    .ctrl     (op),
    .y        (y_nib),
    .cout     (cout),
    .sign     (sign),
    .overflow (ovf)
  );

  // Slice operand selection and completion detection.
  always_comb begin
    perm_to_count = bus.loop_perm_to_count;
    one_nib       = bus.loop_over_one_nibble;
    op            = one_nib ? ALU_ADD : bus.ctrl;
    last_nib      = (curr_nibble_idx_q == 3'd7);
    a_nib         = bus.word1[4*curr_nibble_idx_q +: 4];
    if (one_nib && (curr_nibble_idx_q != 3'd0)) begin
      b_nib = 4'd0;
    end else begin
      b_nib = bus.word2[4*curr_nibble_idx_q +: 4];
    end
    cin        = (curr_nibble_idx_q == 3'd0) ? ctrl_is_sub(op) : carry_q;
    early_done = one_nib && !cout;
    busy       = perm_to_count && !last_nib && !early_done;
    lt         = (op == ALU_SLTU) ? ~cout : (sign ^ ovf);
  end

  // Next-state: advance one slice per permitted cycle, park at nibble 0 otherwise.
  always_comb begin
    curr_nibble_idx_d = curr_nibble_idx_q;
    carry_d           = carry_q;
    result_d          = result_q;
    result_carry_d    = result_carry_q;
    if (!perm_to_count) begin
      curr_nibble_idx_d = 3'd0;
      carry_d           = 1'b0;
    end else begin
      curr_nibble_idx_d = busy ? (curr_nibble_idx_q + 3'd1) : 3'd0;
      carry_d           = cout;
      result_carry_d    = cout;
      if (one_nib && (curr_nibble_idx_q == 3'd0)) begin
        result_d = {bus.word1[31:4], y_nib};
      end else if (last_nib && ((op == ALU_SLT) || (op == ALU_SLTU))) begin
        result_d = {31'd0, lt};
      end else begin
        result_d[4*curr_nibble_idx_q +: 4] = y_nib;
      end
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curr_nibble_idx_q <= 3'd0;
      carry_q           <= 1'b0;
      result_q          <= 32'd0;
      result_carry_q    <= 1'b0;
    end else begin
      curr_nibble_idx_q <= curr_nibble_idx_d;
      carry_q           <= carry_d;
      result_q          <= result_d;
      result_carry_q    <= result_carry_d;
    end
  end

  assign bus.busy         = busy;
  assign bus.result       = result_q;
  assign bus.result_carry = result_carry_q;

endmodule

// File: tb/tb_loop_over_all_nibbles.sv
// Scoreboard bench for the nibble-serial ALU: a word-level reference model
// predicts result, carry and latency for each operation.
module tb_loop_over_all_nibbles;
  import core_pkg::*;

  typedef struct {
    logic [31:0] res;
    logic        carry;
    int          edges;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  exp_t sb_q[$];

  loop_over_all_nibbles_if bus();

  loop_over_all_nibbles dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] w1, input logic [31:0] w2,
                                 input AluCtrl c, input logic one);
    exp_t        r;
    logic [32:0] s;
    logic [63:0] part;
    logic [63:0] mask;
    logic        found;
    r.edges = 8;
    r.carry = 1'b0;
    r.res   = 32'd0;
    if (one) begin
      r.res = w1 + {28'd0, w2[3:0]};
      found = 1'b0;
      for (int i = 0; i < 8; i++) begin
        mask = (64'd1 << (4 * (i + 1))) - 64'd1;
        part = ({32'd0, w1} & mask) + {60'd0, w2[3:0]};
        if (!found && !part[4*(i+1)]) begin
          found   = 1'b1;
          r.edges = i + 1;
          r.carry = 1'b0;
        end
      end
      if (!found) r.carry = 1'b1;
    end else begin
      s = {1'b0, w1} + {1'b0, ~w2} + 33'd1;
      case (c)
        ALU_SUB:  begin r.res = s[31:0]; r.carry = s[32]; end
        ALU_SLT:  begin r.res = ($signed(w1) < $signed(w2)) ? 32'd1 : 32'd0; r.carry = s[32]; end
        ALU_SLTU: begin r.res = (w1 < w2) ? 32'd1 : 32'd0; r.carry = s[32]; end
        ALU_AND:  r.res = w1 & w2;
        ALU_OR:   r.res = w1 | w2;
        ALU_XOR:  r.res = w1 ^ w2;
        default: begin
          s = {1'b0, w1} + {1'b0, w2};
          r.res = s[31:0];
          r.carry = s[32];
        end
      endcase
    end
    return r;
  endfunction

  task automatic run_op(input string tag, input logic [31:0] w1, input logic [31:0] w2,
                        input AluCtrl c, input logic one);
    exp_t e;
    int   edges;
    int   bcnt;
    logic done;
    @(negedge clk);
    bus.word1 = w1;
    bus.word2 = w2;
    bus.ctrl = c;
    bus.loop_over_one_nibble = one;
    bus.loop_perm_to_count = 1'b1;
    sb_q.push_back(model(w1, w2, c, one));
    edges = 0;
    bcnt = 0;
    done = 1'b0;
    while (!done && edges < 20) begin
      #1;
      if (bus.busy) bcnt++;
      else done = 1'b1;
      @(posedge clk);
      edges++;
      @(negedge clk);
    end
    bus.loop_perm_to_count = 1'b0;
    #1;
    e = sb_q.pop_front();
    check_val({tag, "_done"}, {31'd0, done}, 32'd1);
    check_val({tag, "_res"}, bus.result, e.res);
    check_val({tag, "_carry"}, {31'd0, bus.result_carry}, {31'd0, e.carry});
    check_val({tag, "_edges"}, 32'(edges), 32'(e.edges));
    check_val({tag, "_busycyc"}, 32'(bcnt), 32'(e.edges - 1));
    @(negedge clk);
    #1;
    check_val({tag, "_hold"}, bus.result, e.res);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_fail = 0;
    rst_n = 1'b0;
    bus.loop_perm_to_count = 1'b0;
    bus.loop_over_one_nibble = 1'b0;
    bus.ctrl = ALU_ADD;
    bus.word1 = 32'd0;
    bus.word2 = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check_val("rst_result", bus.result, 32'd0);
    check_val("rst_carry", {31'd0, bus.result_carry}, 32'd0);
    check_val("rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("rst_idx", {29'd0, dut.curr_nibble_idx_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add_aeff", 32'h0000AEFF, 32'h00000001, ALU_ADD, 1'b0);
    run_op("add_0_123", 32'd0, 32'd123, ALU_ADD, 1'b0);
    run_op("add_123_2", 32'd123, 32'd2, ALU_ADD, 1'b0);
    run_op("add_wrap", 32'hFFFFFFFF, 32'h00000001, ALU_ADD, 1'b0);
    run_op("sub_5_7", 32'd5, 32'd7, ALU_SUB, 1'b0);
    run_op("sub_7_5", 32'd7, 32'd5, ALU_SUB, 1'b0);
    run_op("slt", 32'hFFFFFFFF, 32'd1, ALU_SLT, 1'b0);
    run_op("sltu", 32'hFFFFFFFF, 32'd1, ALU_SLTU, 1'b0);
    run_op("slt_ovf", 32'h80000000, 32'h7FFFFFFF, ALU_SLT, 1'b0);
    run_op("and", 32'hF0F0F0F0, 32'hFF00FF00, ALU_AND, 1'b0);
    run_op("or", 32'hF0F0F0F0, 32'hFF00FF00, ALU_OR, 1'b0);
    run_op("xor", 32'hF0F0F0F0, 32'hFF00FF00, ALU_XOR, 1'b0);
    run_op("rsvd_add", 32'h12345678, 32'h0F0F0F0F, ALU_RSVD, 1'b0);
    run_op("one_1000", 32'h00001000, 32'd1, ALU_ADD, 1'b1);
    run_op("one_aeff", 32'h0000AEFF, 32'd1, ALU_ADD, 1'b1);
    run_op("one_ffff", 32'hFFFFFFFF, 32'd1, ALU_ADD, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_op("rnd_add", $urandom, $urandom, ALU_ADD, 1'b0);
      run_op("rnd_sub", $urandom, $urandom, ALU_SUB, 1'b0);
    end

    // Reset in the middle of an ADD, then rerun.
    @(negedge clk);
    bus.word1 = 32'h11111111;
    bus.word2 = 32'h22222222;
    bus.ctrl = ALU_ADD;
    bus.loop_over_one_nibble = 1'b0;
    bus.loop_perm_to_count = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check_val("mid_idx", {29'd0, dut.curr_nibble_idx_q}, 32'd3);
    rst_n = 1'b0;
    bus.loop_perm_to_count = 1'b0;
    #1;
    check_val("mid_rst_result", bus.result, 32'd0);
    check_val("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    check_val("mid_rst_idx", {29'd0, dut.curr_nibble_idx_q}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("rerun", 32'h11111111, 32'h22222222, ALU_ADD, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
